// File: rtl/kronos_types.sv
// Kronos shared types: ALU opcode encodings and the buffered EX result entry.
package kronos_types;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // One completed EX result waiting for writeback.
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rd_write;
  } ex_entry_t;

endpackage

// File: rtl/kronos_alu.sv
// Kronos RV32I integer ALU, purely combinational.
module kronos_alu
  import kronos_types::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  aluop,
  output logic [31:0] result
);

  logic signed [31:0] op1_s;
  logic signed [31:0] op2_s;
  logic [4:0]         shamt;

  assign op1_s = $signed(op1);
  assign op2_s = $signed(op2);
  assign shamt = op2[4:0];

  // Select the operation; unknown encodings produce zero.
  always_comb begin
    result = '0;
    case (aluop)
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_SLL:  result = op1 << shamt;
      ALU_SLT:  result = {31'b0, (op1_s < op2_s)};
      ALU_SLTU: result = {31'b0, (op1 < op2)};
      ALU_XOR:  result = op1 ^ op2;
      ALU_SRL:  result = op1 >> shamt;
      ALU_SRA:  result = $unsigned(op1_s >>> shamt);
      ALU_OR:   result = op1 | op2;
      ALU_AND:  result = op1 & op2;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/kronos_ex_stage.sv
// Kronos execute stage: one ALU, a main result register plus optional skid
// register towards writeback, and a combinational RAW forwarding lookup.
module kronos_ex_stage
  import kronos_types::*;
#(
  parameter int SKID_EN = 1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        decode_valid,
  output logic        decode_ready,
  input  logic [31:0] d_op1,
  input  logic [31:0] d_op2,
  input  logic [3:0]  d_aluop,
  input  logic [4:0]  d_rd,
  input  logic        d_rd_write,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_result,
  output logic [4:0]  ex_rd,
  output logic        ex_rd_write,
  input  logic [4:0]  fwd_rs1,
  input  logic [4:0]  fwd_rs2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
);

  logic [31:0] alu_result;
  ex_entry_t   new_entry;
  ex_entry_t   main_q;
  ex_entry_t   skid_q;
  logic        main_valid;
  logic        skid_valid;
  logic        accept;
  logic        drain;

  kronos_alu u_alu (
    .op1    (d_op1),
    .op2    (d_op2),
    .aluop  (d_aluop),
    .result (alu_result)
  );

  assign new_entry = '{result: alu_result, rd: d_rd, rd_write: d_rd_write};
  assign accept    = decode_valid & decode_ready;
  assign drain     = main_valid & ex_ready;

  if (SKID_EN != 0) begin : g_skid
    logic ready_q;
    logic main_valid_d;
    logic skid_valid_d;
    logic main_load;
    logic main_from_skid;
    logic skid_load;

    // Buffer next-state: flush wins, drain refills main from skid (older first).
    always_comb begin
      main_valid_d   = main_valid;
      skid_valid_d   = skid_valid;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      if (flush) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end else if (drain) begin
        if (skid_valid) begin
          main_from_skid = 1'b1;
          skid_valid_d   = 1'b0;
        end else if (accept) begin
          main_load = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        if (main_valid) begin
          skid_load    = 1'b1;
          skid_valid_d = 1'b1;
        end else begin
          main_load    = 1'b1;
          main_valid_d = 1'b1;
        end
      end
    end

    // Control flops and the main entry; ready is a flop mirroring an empty skid.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
        ready_q    <= 1'b0;
        main_q     <= '0;
      end else begin
        main_valid <= main_valid_d;
        skid_valid <= skid_valid_d;
        ready_q    <= ~skid_valid_d;
        if (main_from_skid) begin
          main_q <= skid_q;
        end else if (main_load) begin
          main_q <= new_entry;
        end
      end
    end

    // Skid data carries no reset; skid_valid guards every use.
    always_ff @(posedge clk) begin
      if (skid_load) begin
        skid_q <= new_entry;
      end
    end

    assign decode_ready = ready_q;
  end else begin : g_noskid
    assign skid_valid   = 1'b0;
    assign skid_q       = '0;
    assign decode_ready = ~main_valid | ex_ready;

    // Single result register: flush wins, accept overwrites a draining entry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_valid <= 1'b0;
        main_q     <= '0;
      end else if (flush) begin
        main_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_q     <= new_entry;
      end else if (drain) begin
        main_valid <= 1'b0;
      end
    end
  end

  assign ex_valid    = main_valid;
  assign ex_result   = main_q.result;
  assign ex_rd       = main_q.rd;
  assign ex_rd_write = main_q.rd_write;

  function automatic logic entry_hit(input logic v, input ex_entry_t e, input logic [4:0] rs);
    return v & e.rd_write & (e.rd != 5'd0) & (e.rd == rs);
  endfunction

  function automatic logic [31:0] fwd_value(input logic hit_s, input logic hit_m,
                                            input ex_entry_t s, input ex_entry_t m);
    if (hit_s) return s.result;
    if (hit_m) return m.result;
    return '0;
  endfunction

  // Forwarding lookup: the younger skid entry takes precedence over main.
  always_comb begin
    logic hm1, hs1, hm2, hs2;
    hm1       = entry_hit(main_valid, main_q, fwd_rs1);
    hs1       = entry_hit(skid_valid, skid_q, fwd_rs1);
    hm2       = entry_hit(main_valid, main_q, fwd_rs2);
    hs2       = entry_hit(skid_valid, skid_q, fwd_rs2);
    fwd_hit1  = hm1 | hs1;
    fwd_hit2  = hm2 | hs2;
    fwd_data1 = fwd_value(hs1, hm1, skid_q, main_q);
    fwd_data2 = fwd_value(hs2, hm2, skid_q, main_q);
  end

endmodule

// File: tb/tb_kronos_ex_stage.sv
// Bench for kronos_ex_stage: a SKID_EN=1 and a SKID_EN=0 instance share one
// stimulus stream; each has its own in-order scoreboard queue.
module tb_kronos_ex_stage;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rd_write;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        decode_valid = 1'b0;
  logic        ex_ready = 1'b0;
  logic [31:0] d_op1 = '0;
  logic [31:0] d_op2 = '0;
  logic [3:0]  d_aluop = '0;
  logic [4:0]  d_rd = '0;
  logic        d_rd_write = 1'b0;
  logic [4:0]  fwd_rs1 = '0;
  logic [4:0]  fwd_rs2 = '0;

  logic        decode_ready_v [2];
  logic        ex_valid_v     [2];
  logic [31:0] ex_result_v    [2];
  logic [4:0]  ex_rd_v        [2];
  logic        ex_rd_write_v  [2];
  logic        fwd_hit1_v     [2];
  logic        fwd_hit2_v     [2];
  logic [31:0] fwd_data1_v    [2];
  logic [31:0] fwd_data2_v    [2];

  exp_t sb [2][$];
  int   checks = 0;
  int   errors = 0;
  int   since_rst = 0;
  logic [3:0] ops [10];

  always #5 clk = ~clk;

  kronos_ex_stage #(.SKID_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .decode_valid(decode_valid), .decode_ready(decode_ready_v[1]),
    .d_op1(d_op1), .d_op2(d_op2), .d_aluop(d_aluop), .d_rd(d_rd), .d_rd_write(d_rd_write),
    .ex_valid(ex_valid_v[1]), .ex_ready(ex_ready), .ex_result(ex_result_v[1]),
    .ex_rd(ex_rd_v[1]), .ex_rd_write(ex_rd_write_v[1]),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_hit1(fwd_hit1_v[1]), .fwd_hit2(fwd_hit2_v[1]),
    .fwd_data1(fwd_data1_v[1]), .fwd_data2(fwd_data2_v[1])
  );

  kronos_ex_stage #(.SKID_EN(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .decode_valid(decode_valid), .decode_ready(decode_ready_v[0]),
    .d_op1(d_op1), .d_op2(d_op2), .d_aluop(d_aluop), .d_rd(d_rd), .d_rd_write(d_rd_write),
    .ex_valid(ex_valid_v[0]), .ex_ready(ex_ready), .ex_result(ex_result_v[0]),
    .ex_rd(ex_rd_v[0]), .ex_rd_write(ex_rd_write_v[0]),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_hit1(fwd_hit1_v[0]), .fwd_hit2(fwd_hit2_v[0]),
    .fwd_data1(fwd_data1_v[0]), .fwd_data2(fwd_data2_v[0])
  );

  // Reference ALU written from the instruction semantics.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) since_rst <= 0;
    else if (since_rst < 1000) since_rst <= since_rst + 1;
  end

  // Monitor: forwarding, ready, valid and in-order result checks per instance.
  always @(negedge clk) begin
    if (rst) begin
      sb[0].delete();
      sb[1].delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic        h1, h2, rdy;
        logic [31:0] v1, v2;
        exp_t        e;
        h1 = 1'b0; h2 = 1'b0; v1 = '0; v2 = '0;
        for (int k = 0; k < sb[i].size(); k++) begin
          e = sb[i][k];
          if (e.rd_write && e.rd != 5'd0 && e.rd == fwd_rs1) begin h1 = 1'b1; v1 = e.result; end
          if (e.rd_write && e.rd != 5'd0 && e.rd == fwd_rs2) begin h2 = 1'b1; v2 = e.result; end
        end
        chk($sformatf("dut%0d fwd_hit1", i), 32'(fwd_hit1_v[i]), 32'(h1));
        chk($sformatf("dut%0d fwd_data1", i), fwd_data1_v[i], v1);
        chk($sformatf("dut%0d fwd_hit2", i), 32'(fwd_hit2_v[i]), 32'(h2));
        chk($sformatf("dut%0d fwd_data2", i), fwd_data2_v[i], v2);
        chk($sformatf("dut%0d ex_valid", i), 32'(ex_valid_v[i]), 32'(sb[i].size() != 0));
        if (since_rst > 0) begin
          rdy = (i == 1) ? (sb[i].size() < 2) : (sb[i].size() == 0 || ex_ready);
          chk($sformatf("dut%0d decode_ready", i), 32'(decode_ready_v[i]), 32'(rdy));
        end
        if (ex_valid_v[i] && ex_ready) begin
          if (sb[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected result actual=%h required=none", i, ex_result_v[i]);
          end else begin
            e = sb[i].pop_front();
            chk($sformatf("dut%0d ex_result", i), ex_result_v[i], e.result);
            chk($sformatf("dut%0d ex_rd", i), 32'(ex_rd_v[i]), 32'(e.rd));
            chk($sformatf("dut%0d ex_rd_write", i), 32'(ex_rd_write_v[i]), 32'(e.rd_write));
          end
        end
        if (flush) sb[i].delete();
        else if (decode_valid && decode_ready_v[i])
          sb[i].push_back('{ref_alu(d_aluop, d_op1, d_op2), d_rd, d_rd_write});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until the skid instance accepts it.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic w);
    int n;
    n = 0;
    d_aluop = op; d_op1 = a; d_op2 = b; d_rd = rd; d_rd_write = w;
    decode_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (decode_ready_v[1]) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL issue timeout actual=no_accept required=accept");
        break;
      end
    end
    step();
    decode_valid = 1'b0;
  endtask

  task automatic drain_all();
    ex_ready = 1'b1;
    repeat (4) step();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom % 4)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom % 64);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
    repeat (2) step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst dut%0d ex_valid", i), 32'(ex_valid_v[i]), 32'd0);
      chk($sformatf("rst dut%0d ex_result", i), ex_result_v[i], 32'd0);
      chk($sformatf("rst dut%0d ex_rd", i), 32'(ex_rd_v[i]), 32'd0);
      chk($sformatf("rst dut%0d ex_rd_write", i), 32'(ex_rd_write_v[i]), 32'd0);
    end
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("post-reset decode_ready", 32'(decode_ready_v[1]), 32'd1);
    step();

    // 1: ADD 5+7 -> 12 on rd 3, one cycle later
    ex_ready = 1'b1;
    issue(4'b0000, 32'd5, 32'd7, 5'd3, 1'b1);
    @(negedge clk);
    chk("s1 ex_valid", 32'(ex_valid_v[1]), 32'd1);
    chk("s1 ex_result", ex_result_v[1], 32'd12);
    chk("s1 ex_rd", 32'(ex_rd_v[1]), 32'd3);
    step();

    // 2: backpressure fills main and skid, then ordered drain
    ex_ready = 1'b0;
    issue(4'b1000, 32'd1, 32'd2, 5'd1, 1'b1);
    issue(4'b1101, 32'h8000_0000, 32'd4, 5'd2, 1'b1);
    @(negedge clk);
    chk("s2 decode_ready low", 32'(decode_ready_v[1]), 32'd0);
    chk("s2 held result", ex_result_v[1], 32'hFFFF_FFFF);
    step();
    ex_ready = 1'b1;
    @(negedge clk);
    chk("s2 first result", ex_result_v[1], 32'hFFFF_FFFF);
    step();
    @(negedge clk);
    chk("s2 second result", ex_result_v[1], 32'hF800_0000);
    step();

    // 3: back-to-back compares and shift
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    issue(4'b0001, 32'd1, 32'd31, 5'd6, 1'b1);
    drain_all();

    // 4: forwarding picks the younger skid entry; rd=0 never hits
    ex_ready = 1'b0;
    issue(4'b0000, 32'h11, 32'h0, 5'd5, 1'b1);
    issue(4'b0000, 32'h22, 32'h0, 5'd5, 1'b1);
    fwd_rs1 = 5'd5;
    fwd_rs2 = 5'd0;
    @(negedge clk);
    chk("s4 hit1", 32'(fwd_hit1_v[1]), 32'd1);
    chk("s4 data1", fwd_data1_v[1], 32'h22);
    chk("s4 hit2 rs0", 32'(fwd_hit2_v[1]), 32'd0);
    drain_all();
    ex_ready = 1'b0;
    issue(4'b0000, 32'd1, 32'd1, 5'd0, 1'b1);
    @(negedge clk);
    chk("s4 rd0 hit2", 32'(fwd_hit2_v[1]), 32'd0);
    chk("s4 rd0 data2", fwd_data2_v[1], 32'd0);
    drain_all();

    // 5: flush with both entries full, then with an accept in the flush cycle
    for (int v = 0; v < 2; v++) begin
      ex_ready = 1'b0;
      issue(4'b0000, 32'h10, 32'h1, 5'd7, 1'b1);
      if (v == 0) issue(4'b0000, 32'h20, 32'h1, 5'd8, 1'b1);
      d_aluop = 4'b0000; d_op1 = 32'h99; d_op2 = 32'h0; d_rd = 5'd9; d_rd_write = 1'b1;
      decode_valid = 1'b1;
      flush = 1'b1;
      step();
      decode_valid = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk($sformatf("s5.%0d ex_valid", v), 32'(ex_valid_v[1]), 32'd0);
      chk($sformatf("s5.%0d decode_ready", v), 32'(decode_ready_v[1]), 32'd1);
      drain_all();
    end

    // 6: asynchronous reset mid-stream
    ex_ready = 1'b0;
    issue(4'b0110, 32'hF0, 32'h0F, 5'd10, 1'b1);
    issue(4'b0111, 32'hF0, 32'h3C, 5'd11, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("s6 ex_valid", 32'(ex_valid_v[1]), 32'd0);
    chk("s6 ex_result", ex_result_v[1], 32'd0);
    chk("s6 ex_rd", 32'(ex_rd_v[1]), 32'd0);
    chk("s6 ex_rd_write", 32'(ex_rd_write_v[1]), 32'd0);
    chk("s6 dut0 ex_valid", 32'(ex_valid_v[0]), 32'd0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("s6 decode_ready", 32'(decode_ready_v[1]), 32'd1);
    step();

    // Random traffic with backpressure and occasional flush
    for (int c = 0; c < 600; c++) begin
      ex_ready     = ($urandom % 10) < 6;
      decode_valid = ($urandom % 10) < 7;
      flush        = ($urandom % 40) == 0;
      d_aluop      = ops[$urandom % 10];
      d_op1        = rand_operand();
      d_op2        = rand_operand();
      d_rd         = 5'($urandom % 8);
      d_rd_write   = ($urandom % 4) != 0;
      fwd_rs1      = 5'($urandom % 8);
      fwd_rs2      = 5'($urandom % 8);
      step();
    end
    decode_valid = 1'b0;
    flush = 1'b0;
    drain_all();
    @(negedge clk);
    chk("final dut1 empty", 32'(sb[1].size()), 32'd0);
    chk("final dut0 empty", 32'(sb[0].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
